// File: rtl/mux_nx1_pipe.sv
// N-input registered select stage with valid/ready handshake and a 2-entry skid buffer.
// Latency 1 cycle; in_ready is a flop (skid empty), so a stall never forms a combinational ready path.
module mux_nx1_pipe #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = $clog2(INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*INPUTS-1:0]   in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] mux_dat;
  logic             in_xfer, out_xfer;

  // Selects that match no input fall through to zero.
  always_comb begin
    mux_dat = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (in_sel == SEL_W'(k)) mux_dat = in_data[WIDTH*k +: WIDTH];
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;
  assign out_sel   = main_sel_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_sel_d = main_sel_q;
    skid_dat_d = skid_dat_q;
    skid_sel_d = skid_sel_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_dat_d = mux_dat;
          main_sel_d = in_sel;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_dat_d = mux_dat;
          skid_sel_d = in_sel;
          state_d    = TWO;
        end else if (in_xfer && out_xfer) begin
          main_dat_d = mux_dat;
          main_sel_d = in_sel;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_dat_d = skid_dat_q;
          main_sel_d = skid_sel_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash keeps the stale data/sel; only the valids are dropped.
    if (flush) state_d = EMPTY;
    main_vld_d = (state_d != EMPTY);
    skid_vld_d = (state_d == TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_dat_q <= '0;
      main_sel_q <= '0;
      main_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_sel_q <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_sel_q <= main_sel_d;
      main_vld_q <= main_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_sel_q <= skid_sel_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N-input, W-bit select stage; successor to the fixed 2-input 32-bit datapath mux.
- Used at pipeline-stage boundaries of the MIPS datapath, e.g. forwarding and writeback select.
- Registers its output and carries a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without a combinational ready path.
- Supports a synchronous flush for branch/exception squash.

Parameters:
- WIDTH, 32, data width per input.
- INPUTS, 4, number of inputs N (>=2).
- SEL_W, $clog2(INPUTS), select width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH*INPUTS  flattened inputs; input k occupies [WIDTH*k+WIDTH-1 : WIDTH*k].
- in_sel  input  SEL_W  select, sampled with in_data.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- flush  input  1  synchronous squash of all held beats.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  select that produced out_data (debug/forwarding tag).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst_n=0, asynchronous): out_data=0, out_sel=0, out_valid=0, skid empty, in_ready=1. Deassertion is synchronised by the caller; the block just leaves reset on the next edge.
- Selection: mux result = input[in_sel]. If in_sel >= INPUTS, the result is all zeros (defined, not X).
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Storage: main register (drives outputs) plus skid register, each holding {data, sel, valid}.
- in_ready is registered and equals "skid empty". It does not depend combinationally on out_ready.
- State (occupancy) machine:
  - EMPTY: input transfer loads main; go to ONE.
  - ONE, in transfer only: load skid; go to TWO.
  - ONE, out transfer only: go to EMPTY.
  - ONE, both transfers: main reloads with the new beat; stay in ONE.
  - TWO, out transfer: main takes skid, skid clears; go to ONE. Inputs are blocked because in_ready=0.
  - TWO, no out transfer: hold all state.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data and out_sel are held stable.
- Flush (priority over everything except reset): next edge clears main valid and skid valid, goes to EMPTY, and in_ready becomes 1.
  - A beat presented in the flush cycle is discarded.
  - out_data and out_sel keep their old values but are don't-care while out_valid=0.
- Reset mid-operation: all held beats are lost immediately, with no partial output.
- INPUTS not a power of two: out-of-range selects produce zero, per the selection rule above.

Test Plan:
1. Reset: rst_n=0 mid-stream with 2 beats held -> out_valid=0, in_ready=1, out_data=0 immediately (before the clock edge).
2. Streaming, WIDTH=32, INPUTS=4, out_ready=1, in_valid=1, in_sel cycling 0..3 with inputs 0xA0000000+k -> out_data follows 1 cycle later: 0xA0000000, 0xA0000001, 0xA0000002, 0xA0000003; throughput 1 beat/cycle.
3. Backpressure: send beats D0,D1,D2 with out_ready=0 -> D0 held on the outputs, D1 taken into skid, in_ready=0 on the cycle after D1. D2 is held upstream until space frees. After out_ready=1, output order is D0,D1,D2 with none lost.
4. Out-of-range select with INPUTS=3, in_sel=3 -> out_data=0x00000000, out_sel=3, out_valid=1.
5. Flush with the stage in TWO and flush=1 plus a concurrent in_valid beat -> next cycle out_valid=0, in_ready=1; the concurrent beat never appears at the output.
6. Random soak, WIDTH=8, INPUTS=5: random in_valid, out_ready and sel against a scoreboard queue -> exact ordered match; out_data stable whenever out_valid & !out_ready.
